mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, the operand and result width.
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_ni, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port req_i, input, 1, which is high while a valid M-extension instruction sits in EX.
REQ-005 SHALL have port funct3_i, input, 3, the M-op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-006 SHALL have ports op1_i and op2_i, input, XLEN, the rs1 and rs2 operands.
REQ-007 SHALL have port flush_i, input, 1, the pipeline flush that aborts the current op.
REQ-008 SHALL have port stall_o, output, 1, the pipeline hold request.
REQ-009 SHALL have ports result_o, output, XLEN, and result_valid_o, output, 1, the final result and its one-cycle completion strobe.
REQ-010 SHALL have the multiplier port group: mul_req_o, output, 1; mul_a_o and mul_b_o, output, XLEN; mul_ready_i, input, 1; mul_result_i, input, 2*XLEN.
REQ-011 SHALL have the divider port group: div_req_o, output, 1; div_a_o and div_b_o, output, XLEN; div_is_q_o, output, 1; div_ready_i, input, 1; div_result_i, input, XLEN.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 SHALL, in IDLE with req_i=1, register the conditioned operands, funct3 and sign flags, then go to MUL for MUL* ops or DIV for DIV*/REM* ops.
REQ-014 SHALL condition operands as follows: MUL and MULHU use raw operands; MULH uses |op1| and |op2|; MULHSU uses |op1| and raw op2; DIV and REM use absolute values; DIVU and REMU use raw operands.
REQ-015 SHALL drive mul_req_o and div_req_o from registers only, held high from the cycle after capture until the cycle in which the matching ready is sampled high, then low.
REQ-016 SHALL, when ready is sampled high, register the sign-corrected result and go to DONE.
REQ-017 SHALL apply sign correction as follows: negate the 2*XLEN product when MULH and op1 sign differs from op2 sign, or when MULHSU and op1 is negative; negate the quotient when DIV and signs differ; give the REM remainder the sign of op1.
REQ-018 SHALL, for divide by zero, skip the divider and go IDLE to DONE directly: DIV/DIVU give all ones, REM/REMU give op1.
REQ-019 SHALL, for DIV/REM with op1 = 2^(XLEN-1) and op2 = all ones, skip the divider: quotient = op1, remainder = 0.
REQ-020 SHALL, in DONE, pulse result_valid_o for exactly one cycle, deassert stall_o, and return to IDLE unconditionally (no restart from the same req_i).
REQ-021 SHALL compute stall_o = (IDLE and req_i) or MUL or DIV; stall_o SHALL be 0 in DONE.
REQ-022 SHALL give a latency from req_i to result_valid_o of unit latency + 2 cycles, or 1 cycle for the special cases.
REQ-023 SHALL, on flush_i in any state, return to IDLE next cycle, drop the req outputs, and suppress result_valid_o; flush_i has priority over a simultaneous ready.
REQ-024 SHALL hold result_o stable until the next completion.
REQ-025 SHALL ignore a ready input that arrives while its req output is low.
REQ-026 SHALL drive div_is_q_o = 1 for DIV/DIVU and 0 for REM/REMU, stable while div_req_o is high.

Reset
REQ-027 SHALL, while rst_ni is low, asynchronously force state=IDLE, all registered outputs = 0, stall_o = 0, and result_valid_o = 0.
REQ-028 SHALL, on reset mid-operation, discard the in-flight op; the unit abort relies on req dropping.

Structure
REQ-029 SHALL place the funct3 encodings, state encodings and XLEN default in the shared defines header.
REQ-030 SHALL put operand conditioning and result sign-fix in one combinational sub-module, mdu_sign_fix; FSM and registers stay in mdu_ctrl.

Verification
REQ-031 SHALL verify: MULH op1 = 0xFFFFFFFD (-3), op2 = 5 -> result 0xFFFFFFFF; MUL of the same operands -> 0xFFFFFFF1; stall_o high until DONE.
REQ-032 SHALL verify: DIV op1 = 0x80000000, op2 = 0xFFFFFFFF -> 0x80000000 at 1-cycle latency, with div_req_o never high.
REQ-033 SHALL verify: DIVU 9/0 -> 0xFFFFFFFF and REM 7/0 -> 7, with no divider request.
REQ-034 SHALL verify: REM op1 = 0xFFFFFFF9 (-7), op2 = 2 -> 0xFFFFFFFF; DIV of the same operands -> 0xFFFFFFFD.
REQ-035 SHALL verify: flush_i in the cycle after div_req_o rises -> no result_valid_o, div_req_o low next cycle, and the next MUL completes correctly.
REQ-036 SHALL verify: rst_ni low mid-MUL -> all outputs 0 immediately, and an op issued after reset release completes correctly.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the M-extension controller: funct3 codes, FSM states
// and the default datapath width.
package mdu_ctrl_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  // DIV and REM are the signed divide ops (funct3 bit 0 clear).
  function automatic logic is_signed_div(input logic [2:0] f3);
    return f3[2] & ~f3[0];
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Handshake bundle between the M-extension controller and the external
// multiplier / divider units.
interface mdu_ctrl_if
  import mdu_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic              mul_req_o;
  logic [XLEN-1:0]   mul_a_o;
  logic [XLEN-1:0]   mul_b_o;
  logic              mul_ready_i;
  logic [2*XLEN-1:0] mul_result_i;

  logic              div_req_o;
  logic [XLEN-1:0]   div_a_o;
  logic [XLEN-1:0]   div_b_o;
  logic              div_is_q_o;
  logic              div_ready_i;
  logic [XLEN-1:0]   div_result_i;

  modport master (
    output mul_req_o, mul_a_o, mul_b_o,
    input  mul_ready_i, mul_result_i,
    output div_req_o, div_a_o, div_b_o, div_is_q_o,
    input  div_ready_i, div_result_i
  );

  modport slave (
    input  mul_req_o, mul_a_o, mul_b_o,
    output mul_ready_i, mul_result_i,
    input  div_req_o, div_a_o, div_b_o, div_is_q_o,
    output div_ready_i, div_result_i
  );

endinterface

// File: rtl/mdu_sign_fix.sv
// Combinational operand conditioning (magnitudes for signed ops) and the
// matching sign correction of the unsigned unit results.
module mdu_sign_fix
  import mdu_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   op1,
  input  logic [XLEN-1:0]   op2,
  output logic [XLEN-1:0]   op_a,
  output logic [XLEN-1:0]   op_b,
  output logic              neg,
  input  logic [2:0]        fix_funct3,
  input  logic              fix_neg,
  input  logic [2*XLEN-1:0] mul_prod,
  input  logic [XLEN-1:0]   div_res,
  output logic [XLEN-1:0]   fixed_res
);

  function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v);
    logic signed [XLEN-1:0] n;
    n = -v;
    return v[XLEN-1] ? n : v;
  endfunction

  logic                     s1, s2;
  logic signed [2*XLEN-1:0] prod_s, prod_fix;
  logic signed [XLEN-1:0]   div_s, div_fix;

  assign s1 = op1[XLEN-1];
  assign s2 = op2[XLEN-1];

  always_comb begin
    op_a = op1;
    op_b = op2;
    neg  = 1'b0;
    case (funct3)
      F3_MULH:   begin op_a = abs_val(op1); op_b = abs_val(op2); neg = s1 ^ s2; end
      F3_MULHSU: begin op_a = abs_val(op1); neg = s1; end
      F3_DIV:    begin op_a = abs_val(op1); op_b = abs_val(op2); neg = s1 ^ s2; end
      F3_REM:    begin op_a = abs_val(op1); op_b = abs_val(op2); neg = s1; end
      default:   ;
    endcase
  end

  // Negation is applied to the full 2*XLEN product before the high half is taken.
  always_comb begin
    prod_s   = mul_prod;
    prod_fix = fix_neg ? -prod_s : prod_s;
    div_s    = div_res;
    div_fix  = fix_neg ? -div_s : div_s;
    if (fix_funct3[2])
      fixed_res = div_fix;
    else if (fix_funct3 == F3_MUL)
      fixed_res = prod_fix[XLEN-1:0];
    else
      fixed_res = prod_fix[2*XLEN-1:XLEN];
  end

endmodule

// File: rtl/mdu_ctrl.sv
// M-extension sequencer: captures an op from EX, drives the external multiplier
// or divider, sign-corrects the result and stalls the pipeline meanwhile.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  mdu_ctrl_if.master      unit_if
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state;
  logic [2:0]      funct3_q;
  logic            neg_q;
  logic            mul_req_q;
  logic            div_req_q;
  logic            is_q_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] result_q;

  logic [XLEN-1:0] cond_a, cond_b, fixed_res;
  logic            cond_neg, div_zero, div_ovf;

  mdu_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .funct3     (funct3_i),
    .op1        (op1_i),
    .op2        (op2_i),
    .op_a       (cond_a),
    .op_b       (cond_b),
    .neg        (cond_neg),
    .fix_funct3 (funct3_q),
    .fix_neg    (neg_q),
    .mul_prod   (unit_if.mul_result_i),
    .div_res    (unit_if.div_result_i),
    .fixed_res  (fixed_res)
  );

  // Cases the divider never sees: x/0 and the signed INT_MIN / -1 overflow.
  assign div_zero = (op2_i == '0);
  assign div_ovf  = is_signed_div(funct3_i) && (op1_i == INT_MIN) && (op2_i == '1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      funct3_q  <= 3'b000;
      neg_q     <= 1'b0;
      mul_req_q <= 1'b0;
      div_req_q <= 1'b0;
      is_q_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
    end else if (flush_i) begin
      state     <= ST_IDLE;
      mul_req_q <= 1'b0;
      div_req_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_i) begin
            funct3_q <= funct3_i;
            neg_q    <= cond_neg;
            a_q      <= cond_a;
            b_q      <= cond_b;
            is_q_q   <= ~funct3_i[1];
            if (!is_div_op(funct3_i)) begin
              mul_req_q <= 1'b1;
              state     <= ST_MUL;
            end else if (div_zero) begin
              result_q <= funct3_i[1] ? op1_i : '1;
              state    <= ST_DONE;
            end else if (div_ovf) begin
              result_q <= funct3_i[1] ? '0 : op1_i;
              state    <= ST_DONE;
            end else begin
              div_req_q <= 1'b1;
              state     <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          if (mul_req_q && unit_if.mul_ready_i) begin
            result_q  <= fixed_res;
            mul_req_q <= 1'b0;
            state     <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (div_req_q && unit_if.div_ready_i) begin
            result_q  <= fixed_res;
            div_req_q <= 1'b0;
            state     <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // rst_ni gates stall so a pending req_i cannot hold the pipeline during reset.
  assign stall_o = rst_ni & (((state == ST_IDLE) & req_i) | (state == ST_MUL) | (state == ST_DIV));
  assign result_valid_o = (state == ST_DONE) & ~flush_i;
  assign result_o       = result_q;

  assign unit_if.mul_req_o  = mul_req_q;
  assign unit_if.mul_a_o    = a_q;
  assign unit_if.mul_b_o    = b_q;
  assign unit_if.div_req_o  = div_req_q;
  assign unit_if.div_a_o    = a_q;
  assign unit_if.div_b_o    = b_q;
  assign unit_if.div_is_q_o = is_q_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with behavioural fixed-latency multiplier and
// divider units attached through the handshake interface.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 3;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b1;
  logic            req_i = 1'b0;
  logic [2:0]      funct3_i = 3'b000;
  logic [XLEN-1:0] op1_i = '0;
  logic [XLEN-1:0] op2_i = '0;
  logic            flush_i = 1'b0;
  logic            stall_o;
  logic [XLEN-1:0] result_o;
  logic            result_valid_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mdu_ctrl_if #(.XLEN(XLEN)) uif ();

  mdu_ctrl #(.XLEN(XLEN)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .funct3_i       (funct3_i),
    .op1_i          (op1_i),
    .op2_i          (op2_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .unit_if        (uif)
  );

  // Unit models: ready comes LAT cycles after req rises, result is plain unsigned.
  int mul_cnt = 0;
  int div_cnt = 0;
  always @(posedge clk) begin
    mul_cnt <= uif.mul_req_o ? mul_cnt + 1 : 0;
    div_cnt <= uif.div_req_o ? div_cnt + 1 : 0;
  end
  assign uif.mul_ready_i  = uif.mul_req_o && (mul_cnt == MUL_LAT);
  assign uif.mul_result_i = {{XLEN{1'b0}}, uif.mul_a_o} * {{XLEN{1'b0}}, uif.mul_b_o};
  assign uif.div_ready_i  = uif.div_req_o && (div_cnt == DIV_LAT);
  assign uif.div_result_i = (uif.div_b_o == '0) ? 32'hDEADBEEF :
                            (uif.div_is_q_o ? uif.div_a_o / uif.div_b_o : uif.div_a_o % uif.div_b_o);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [XLEN-1:0] res;
  int              lat;
  bit              stall_ok, saw_mul, saw_div, got_valid, stall_at_done, last_isq;

  task automatic do_op(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req_i = 1'b1; funct3_i = f3; op1_i = a; op2_i = b;
    stall_ok = 1'b1; saw_mul = 1'b0; saw_div = 1'b0; got_valid = 1'b0; lat = 0;
    @(negedge clk);
    if (!stall_o) stall_ok = 1'b0;
    while (!got_valid && lat < 40) begin
      @(posedge clk); #1;
      req_i = 1'b0;
      lat++;
      saw_mul |= uif.mul_req_o;
      saw_div |= uif.div_req_o;
      if (uif.div_req_o) last_isq = uif.div_is_q_o;
      if (result_valid_o) begin
        got_valid     = 1'b1;
        res           = result_o;
        stall_at_done = stall_o;
      end else if (!stall_o) begin
        stall_ok = 1'b0;
      end
    end
  endtask

  task automatic op_check(input string tag, input logic [2:0] f3,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp);
    do_op(f3, a, b);
    check({tag, "_valid"}, got_valid, 1);
    check(tag, res, exp);
    @(posedge clk); #1;
    check({tag, "_pulse"}, result_valid_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state, with req_i high to show stall is held low in reset.
    #1 rst_ni = 1'b0; req_i = 1'b1;
    #2;
    check("rst_stall", stall_o, 0);
    check("rst_valid", result_valid_o, 0);
    check("rst_result", result_o, 0);
    check("rst_mul_req", uif.mul_req_o, 0);
    check("rst_div_req", uif.div_req_o, 0);
    req_i = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Multiplies
    op_check("mulh_neg", F3_MULH, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF);
    check("mulh_lat", lat, MUL_LAT + 2);
    check("mulh_stall_held", stall_ok, 1);
    check("mulh_stall_done", stall_at_done, 0);
    op_check("mul_low", F3_MUL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1);
    op_check("mulhu", F3_MULHU, 32'hFFFFFFFD, 32'd5, 32'h00000004);
    op_check("mulhsu_neg", F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    op_check("mulhsu_pos", F3_MULHSU, 32'd2, 32'hFFFFFFFF, 32'h00000001);
    op_check("mulh_negneg", F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);

    // Divide special cases
    op_check("div_ovf", F3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    check("div_ovf_lat", lat, 1);
    check("div_ovf_no_req", saw_div, 0);
    op_check("rem_ovf", F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
    op_check("divu_zero", F3_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF);
    check("divu_zero_no_req", saw_div, 0);
    op_check("rem_zero", F3_REM, 32'd7, 32'd0, 32'd7);
    check("rem_zero_no_req", saw_div, 0);
    check("rem_zero_lat", lat, 1);

    // Regular divides
    op_check("rem_neg", F3_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    check("rem_isq", last_isq, 0);
    op_check("div_neg", F3_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    check("div_lat", lat, DIV_LAT + 2);
    check("div_isq", last_isq, 1);
    check("div_no_mul", saw_mul, 0);
    op_check("divu", F3_DIVU, 32'd100, 32'd7, 32'd14);
    op_check("remu", F3_REMU, 32'd100, 32'd7, 32'd2);
    op_check("div_min_by2", F3_DIV, 32'h80000000, 32'd2, 32'hC0000000);
    repeat (3) @(posedge clk);
    #1 check("result_hold", result_o, 32'hC0000000);

    // Flush one cycle after div_req_o rises
    req_i = 1'b1; funct3_i = F3_DIVU; op1_i = 32'd100; op2_i = 32'd7;
    @(posedge clk); #1 req_i = 1'b0;
    check("flush_div_req_up", uif.div_req_o, 1);
    @(posedge clk); #1 flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
    check("flush_div_req_drop", uif.div_req_o, 0);
    check("flush_div_stall", stall_o, 0);
    got_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (result_valid_o) got_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("flush_div_no_valid", got_valid, 0);
    check("flush_div_hold", result_o, 32'hC0000000);
    op_check("mul_after_flush", F3_MUL, 32'd7, 32'd6, 32'd42);

    // Flush in the same cycle the multiplier is ready: flush wins
    req_i = 1'b1; funct3_i = F3_MUL; op1_i = 32'd3; op2_i = 32'd4;
    @(posedge clk); #1 req_i = 1'b0;
    repeat (MUL_LAT) @(posedge clk);
    #1 flush_i = 1'b1;
    check("flush_rdy_mul_req", uif.mul_req_o, 1);
    @(posedge clk); #1 flush_i = 1'b0;
    check("flush_rdy_no_valid", result_valid_o, 0);
    check("flush_rdy_mul_drop", uif.mul_req_o, 0);
    check("flush_rdy_hold", result_o, 32'd42);

    // Asynchronous reset in the middle of a multiply
    repeat (2) @(posedge clk);
    #1 req_i = 1'b1; funct3_i = F3_MUL; op1_i = 32'h1234; op2_i = 32'h10;
    @(posedge clk); #1;
    check("rstmid_mul_req_up", uif.mul_req_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("rstmid_stall", stall_o, 0);
    check("rstmid_valid", result_valid_o, 0);
    check("rstmid_result", result_o, 0);
    check("rstmid_mul_req", uif.mul_req_o, 0);
    check("rstmid_mul_a", uif.mul_a_o, 0);
    check("rstmid_mul_b", uif.mul_b_o, 0);
    check("rstmid_div_req", uif.div_req_o, 0);
    req_i = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    @(posedge clk); #1;
    op_check("mul_after_rst", F3_MUL, 32'h1234, 32'h10, 32'h12340);
    check("mul_after_rst_lat", lat, MUL_LAT + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
